// File: rtl/multicycle_control_unit.sv
// Moore control FSM sequencing the multicycle MIPS DataPath: fetch/decode,
// LW/SW/R-type/BEQ/ADDI execution, plus interrupt and illegal-opcode trapping.
module multicycle_control_unit #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       irq,
    output logic [1:0] aluControl,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic       pcSource,
    output logic       pcWrite,
    output logic       isBranch,
    output logic       lorD,
    output logic       memWrite,
    output logic       memToReg,
    output logic       IrWrite,
    output logic       regDst,
    output logic       regWrite,
    output logic       isInterrupted,
    output logic       intAck,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADR   = 4'd3,
        S_MEM_RD    = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WR    = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BEQ       = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_INTR      = 4'd12
    } state_t;

    typedef struct packed {
        logic [1:0] alu_control;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_source;
        logic       pc_write;
        logic       is_branch;
        logic       lor_d;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       is_interrupted;
        logic       int_ack;
    } ctrl_t;

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    logic   r_pending;
    logic   r_is_sw;
    logic   w_pend_next;
    logic   w_unused_funct;

    // funct is decoded by the ALU control block, not here
    assign w_unused_funct = ^funct;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE:    c.alu_src_b = 2'b11;
            S_MEM_ADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_RD:    c.lor_d = 1'b1;
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                c.lor_d     = 1'b1;
                c.mem_write = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = 2'b10;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = 2'b01;
                c.is_branch   = 1'b1;
                c.pc_source   = 1'b1;
            end
            S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDI_WB:   c.reg_write = 1'b1;
            S_INTR: begin
                c.is_interrupted = 1'b1;
                c.pc_write       = 1'b1;
                c.int_ack        = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      w_next = S_FETCH;
            S_FETCH:     w_next = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) w_next = S_MEM_ADR;
                else if (op == OP_RTYPE)        w_next = S_R_EXEC;
                else if (op == OP_BEQ)          w_next = S_BEQ;
                else if (op == OP_ADDI)         w_next = S_ADDI_EXEC;
                else                            w_next = S_INTR;
            end
            // LW/SW choice was latched in DECODE; op is not looked at again
            S_MEM_ADR:   w_next = r_is_sw ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    w_next = S_MEM_WB;
            S_R_EXEC:    w_next = S_R_WB;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            S_MEM_WB, S_MEM_WR, S_R_WB, S_BEQ, S_ADDI_WB, S_INTR:
                w_next = r_pending ? S_INTR : S_FETCH;
            default:     w_next = S_IDLE;
        endcase
    end

    assign w_pend_next = irq | (r_pending & (w_next != S_INTR));

    // Outputs are decoded from the next state so they register alongside it
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= S_IDLE;
            r_ctrl    <= '0;
            r_pending <= 1'b0;
            r_is_sw   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ctrl    <= decode(w_next);
            r_pending <= w_pend_next;
            if (r_state == S_DECODE) r_is_sw <= (op == OP_SW);
        end
    end

    assign aluControl    = r_ctrl.alu_control;
    assign aluSrcA       = r_ctrl.alu_src_a;
    assign aluSrcB       = r_ctrl.alu_src_b;
    assign pcSource      = r_ctrl.pc_source;
    assign pcWrite       = r_ctrl.pc_write;
    assign isBranch      = r_ctrl.is_branch;
    assign lorD          = r_ctrl.lor_d;
    assign memWrite      = r_ctrl.mem_write;
    assign memToReg      = r_ctrl.mem_to_reg;
    assign IrWrite       = r_ctrl.ir_write;
    assign regDst        = r_ctrl.reg_dst;
    assign regWrite      = r_ctrl.reg_write;
    assign isInterrupted = r_ctrl.is_interrupted;
    assign intAck        = r_ctrl.int_ack;
    assign state         = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed vector bench for multicycle_control_unit: per-cycle state and
// control-word checks against a hand-written state/output table.
module tb_multicycle_control_unit;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;

    typedef struct packed {
        logic [1:0] alu_control;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_source;
        logic       pc_write;
        logic       is_branch;
        logic       lor_d;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       is_interrupted;
        logic       int_ack;
    } ctrl_t;

    typedef struct {
        logic [5:0] op;
        logic       irq;
        logic [3:0] st;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'b100000;
    logic       irq = 1'b0;
    logic [1:0] aluControl;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       pcSource, pcWrite, isBranch, lorD, memWrite, memToReg;
    logic       IrWrite, regDst, regWrite, isInterrupted, intAck;
    logic [3:0] state;
    ctrl_t      dut_ctrl;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .resetN(resetN), .op(op), .funct(funct), .irq(irq),
        .aluControl(aluControl), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .pcSource(pcSource), .pcWrite(pcWrite), .isBranch(isBranch),
        .lorD(lorD), .memWrite(memWrite), .memToReg(memToReg),
        .IrWrite(IrWrite), .regDst(regDst), .regWrite(regWrite),
        .isInterrupted(isInterrupted), .intAck(intAck), .state(state)
    );

    assign dut_ctrl = '{alu_control: aluControl, alu_src_a: aluSrcA, alu_src_b: aluSrcB,
                        pc_source: pcSource, pc_write: pcWrite, is_branch: isBranch,
                        lor_d: lorD, mem_write: memWrite, mem_to_reg: memToReg,
                        ir_write: IrWrite, reg_dst: regDst, reg_write: regWrite,
                        is_interrupted: isInterrupted, int_ack: intAck};

    // Expected control word per state, written out from the output table
    function automatic ctrl_t exp_ctrl(input logic [3:0] s);
        ctrl_t c;
        c = '0;
        case (s)
            4'd1:  begin c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 2'b01; end
            4'd2:  c.alu_src_b = 2'b11;
            4'd3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd4:  c.lor_d = 1;
            4'd5:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            4'd6:  begin c.lor_d = 1; c.mem_write = 1; end
            4'd7:  begin c.alu_src_a = 1; c.alu_control = 2'b10; end
            4'd8:  begin c.reg_write = 1; c.reg_dst = 1; end
            4'd9:  begin c.alu_src_a = 1; c.alu_control = 2'b01; c.is_branch = 1; c.pc_source = 1; end
            4'd10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd11: c.reg_write = 1;
            4'd12: begin c.is_interrupted = 1; c.pc_write = 1; c.int_ack = 1; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    endtask

    task automatic check_state(input string tag, input logic [3:0] s);
        check({tag, ".state"}, 32'(state), 32'(s));
        check({tag, ".ctrl"}, 32'(dut_ctrl), 32'(exp_ctrl(s)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [5:0] o, input logic i, input logic [3:0] s);
        vec_t v;
        v.op = o; v.irq = i; v.st = s;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // R-type
        add(RT, 0, 2); add(RT, 0, 7); add(RT, 0, 8); add(RT, 0, 1);
        // LW then SW
        add(LW, 0, 2); add(LW, 0, 3); add(LW, 0, 4); add(LW, 0, 5); add(LW, 0, 1);
        add(SW, 0, 2); add(SW, 0, 3); add(SW, 0, 6); add(SW, 0, 1);
        // BEQ and ADDI
        add(BEQ, 0, 2); add(BEQ, 0, 9); add(BEQ, 0, 1);
        add(ADDI, 0, 2); add(ADDI, 0, 10); add(ADDI, 0, 11); add(ADDI, 0, 1);
        // op changing after DECODE is ignored
        add(RT, 0, 2); add(RT, 0, 7); add(SW, 0, 8); add(SW, 0, 1);
        // irq pulse during R_EXEC: finish R_WB, one INTR, then normal flow
        add(RT, 0, 2); add(RT, 0, 7); add(RT, 1, 8); add(RT, 0, 12); add(RT, 0, 1);
        add(RT, 0, 2); add(RT, 0, 7); add(RT, 0, 8); add(RT, 0, 1);
        // illegal opcode trap
        add(BAD, 0, 2); add(BAD, 0, 12); add(BAD, 0, 1);
        // irq during INTR re-arms; taken only at the next instruction boundary
        add(BAD, 0, 2); add(BAD, 0, 12); add(BAD, 1, 1);
        add(ADDI, 0, 2); add(ADDI, 0, 10); add(ADDI, 0, 11); add(ADDI, 0, 12); add(ADDI, 0, 1);

        // Reset state, held across edges
        #2;
        check_state("reset", 4'd0);
        step();
        check_state("reset_hold", 4'd0);
        resetN = 1'b1;
        step();
        check_state("release", 4'd1);

        foreach (vecs[i]) begin
            op  = vecs[i].op;
            irq = vecs[i].irq;
            step();
            check_state($sformatf("vec%0d", i), vecs[i].st);
        end
        irq = 1'b0;

        // Mid-SW reset with an interrupt pending: memWrite drops at once, pending lost
        op = SW;
        step(); check_state("sw_dec", 4'd2);
        step(); check_state("sw_adr", 4'd3);
        irq = 1'b1;
        step(); check_state("sw_wr", 4'd6);
        irq = 1'b0;
        op = BAD;
        resetN = 1'b0;
        #1;
        check("midreset.memWrite", 32'(memWrite), 32'd0);
        check_state("midreset", 4'd0);
        step();
        resetN = 1'b1;
        op = BEQ;
        step(); check_state("rr_fetch", 4'd1);
        step(); check_state("rr_dec", 4'd2);
        step(); check_state("rr_beq", 4'd9);
        step(); check_state("rr_nopend", 4'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
